// File: rtl/prism_axi_pkg.sv
// Shared types and defaults for the AXI ID scheduler slice.
package prism_axi_pkg;

  typedef enum logic [0:0] {
    S_ARB   = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int MAX_OUT_DEF = 4;

endpackage

// File: rtl/prism_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping.
module prism_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int REQ_WIDTH = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]      eligible_i,
  input  logic [REQ_WIDTH-1:0] ptr_i,
  output logic [NREQ-1:0]      grant_o,
  output logic [REQ_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  logic [REQ_WIDTH:0]   sum_s;
  logic [REQ_WIDTH-1:0] cand_s;

  // Scan candidates in rotated order and latch the first hit.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_i} + (REQ_WIDTH+1)'(k);
      if (sum_s >= (REQ_WIDTH+1)'(NREQ)) begin
        sum_s = sum_s - (REQ_WIDTH+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[REQ_WIDTH-1:0];
      if (!any_o && eligible_i[cand_s]) begin
        any_o           = 1'b1;
        grant_o[cand_s] = 1'b1;
        idx_o           = cand_s;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/prism_axi_id_scheduler.sv
// Shares one AXI ID pool among NREQ requesters: round-robin grants, owner
// tracking, response routing and ID return to the allocator.
module prism_axi_id_scheduler
  import prism_axi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NIDS      = 8,
  parameter int ID_WIDTH  = $clog2(NIDS),
  parameter int REQ_WIDTH = $clog2(NREQ),
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  output logic [ID_WIDTH-1:0]  req_id,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [ID_WIDTH-1:0]  alloc_id,
  output logic                 dealloc_valid,
  input  logic                 dealloc_ready,
  output logic [ID_WIDTH-1:0]  dealloc_id,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [ID_WIDTH-1:0]  rsp_id,
  input  logic                 rsp_last,
  output logic [REQ_WIDTH-1:0] rsp_owner,
  output logic [NREQ-1:0]      done_valid,
  output logic [ID_WIDTH-1:0]  done_id,
  output logic                 err
);

  localparam int CW = $clog2(MAX_OUT + 1);

  state_t               state_q, state_d;
  logic [REQ_WIDTH-1:0] win_q, win_d;
  logic [NREQ-1:0]      win_oh_q, win_oh_d;
  logic [REQ_WIDTH-1:0] ptr_q, ptr_d;
  logic [NIDS-1:0]      busy_q, busy_d;
  logic [REQ_WIDTH-1:0] owner_q [NIDS];
  logic [REQ_WIDTH-1:0] owner_d [NIDS];
  logic [CW-1:0]        cnt_q [NREQ];
  logic [CW-1:0]        cnt_d [NREQ];
  logic                 pend_q, pend_d;
  logic [ID_WIDTH-1:0]  pend_id_q, pend_id_d;
  logic [NREQ-1:0]      done_valid_q, done_valid_d;
  logic [ID_WIDTH-1:0]  done_id_q, done_id_d;
  logic                 err_q, err_d;

  logic [NREQ-1:0]      eligible_s;
  logic [NREQ-1:0]      arb_grant_s;
  logic [REQ_WIDTH-1:0] arb_idx_s;
  logic                 arb_any_s;
  logic                 grant_fire_s;
  logic                 dealloc_fire_s;
  logic                 rsp_fire_s;
  logic [REQ_WIDTH-1:0] free_owner_s;

  // A requester at its outstanding cap is simply invisible to the arbiter.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible_s[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
    end
  end

  prism_rr_arbiter #(
    .NREQ      (NREQ),
    .REQ_WIDTH (REQ_WIDTH)
  ) u_arb (
    .eligible_i (eligible_s),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant_s),
    .idx_o      (arb_idx_s),
    .any_o      (arb_any_s)
  );

  assign grant_fire_s   = (state_q == S_GRANT);
  assign dealloc_fire_s = pend_q && dealloc_ready;
  assign rsp_fire_s     = rsp_valid && !pend_q;
  assign free_owner_s   = owner_q[pend_id_q];

  // Arbitration FSM: pick a winner, then hold the grant for exactly one cycle.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    case (state_q)
      S_ARB: begin
        if (alloc_valid && arb_any_s) begin
          state_d  = S_GRANT;
          win_d    = arb_idx_s;
          win_oh_d = arb_grant_s;
        end else begin
          state_d = S_ARB;
        end
      end
      S_GRANT: state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  always_comb begin
    req_ready = grant_fire_s ? win_oh_q : '0;
  end

  assign alloc_ready = grant_fire_s;
  assign req_id      = alloc_id;

  // Busy/owner tables and pointer; a free and a grant in one cycle both apply.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (dealloc_fire_s) begin
      busy_d[pend_id_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (grant_fire_s) begin
      busy_d[alloc_id]  = 1'b1;
      owner_d[alloc_id] = win_q;
      ptr_d = (win_q == REQ_WIDTH'(NREQ - 1)) ? '0 : win_q + REQ_WIDTH'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Outstanding counters: grant and free to the same requester cancel.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_fire_s && (win_q == REQ_WIDTH'(i)) &&
          !(dealloc_fire_s && (free_owner_s == REQ_WIDTH'(i)))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dealloc_fire_s && (free_owner_s == REQ_WIDTH'(i)) &&
                   !(grant_fire_s && (win_q == REQ_WIDTH'(i)))) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Response capture, ID return handshake, done pulse and sticky error.
  always_comb begin
    pend_d       = pend_q;
    pend_id_d    = pend_id_q;
    done_valid_d = '0;
    done_id_d    = done_id_q;
    err_d        = err_q;
    if (rsp_fire_s && rsp_last) begin
      pend_d    = 1'b1;
      pend_id_d = rsp_id;
    end else if (dealloc_fire_s) begin
      pend_d                     = 1'b0;
      done_valid_d[free_owner_s] = 1'b1;
      done_id_d                  = pend_id_q;
    end else begin
      pend_d = pend_q;
    end
    if (rsp_fire_s && !busy_q[rsp_id]) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  assign rsp_ready     = !pend_q;
  assign dealloc_valid = pend_q;
  assign dealloc_id    = pend_id_q;
  assign rsp_owner     = owner_q[rsp_id];
  assign done_valid    = done_valid_q;
  assign done_id       = done_id_q;
  assign err           = err_q;

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_ARB;
      win_q        <= '0;
      win_oh_q     <= '0;
      ptr_q        <= '0;
      busy_q       <= '0;
      pend_q       <= 1'b0;
      pend_id_q    <= '0;
      done_valid_q <= '0;
      done_id_q    <= '0;
      err_q        <= 1'b0;
      for (int n = 0; n < NIDS; n++) owner_q[n] <= '0;
      for (int r = 0; r < NREQ; r++) cnt_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      win_oh_q     <= win_oh_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      pend_id_q    <= pend_id_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      err_q        <= err_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prism_axi_id_scheduler.sv
// Directed bench for prism_axi_id_scheduler (NREQ=4, NIDS=8, MAX_OUT=2).
module tb_prism_axi_id_scheduler;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [2:0] req_id;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [2:0] alloc_id;
  logic       dealloc_valid;
  logic       dealloc_ready;
  logic [2:0] dealloc_id;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_id;
  logic       rsp_last;
  logic [1:0] rsp_owner;
  logic [3:0] done_valid;
  logic [2:0] done_id;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  prism_axi_id_scheduler #(
    .NREQ    (4),
    .NIDS    (8),
    .MAX_OUT (2)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_id        (req_id),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_id      (alloc_id),
    .dealloc_valid (dealloc_valid),
    .dealloc_ready (dealloc_ready),
    .dealloc_id    (dealloc_id),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_last      (rsp_last),
    .rsp_owner     (rsp_owner),
    .done_valid    (done_valid),
    .done_id       (done_id),
    .err           (err)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset;
    resetn        = 1'b0;
    req_valid     = 4'b0000;
    alloc_valid   = 1'b0;
    alloc_id      = 3'd0;
    dealloc_ready = 1'b0;
    rsp_valid     = 1'b0;
    rsp_id        = 3'd0;
    rsp_last      = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
  endtask

  task automatic do_grant(input logic [3:0] rv, input logic [2:0] id, input logic [3:0] exp_ready);
    req_valid   = rv;
    alloc_valid = 1'b1;
    alloc_id    = id;
    tick;
    chk("grant_ready", 32'(req_ready), 32'(exp_ready));
    chk("grant_id", 32'(req_id), 32'(id));
    chk("grant_alloc_ready", 32'(alloc_ready), 32'd1);
    alloc_valid = 1'b0;
    tick;
    chk("grant_pulse_end", 32'(req_ready), 32'd0);
  endtask

  logic [2:0] fair_ids [8];
  logic [3:0] onehot;

  initial begin
    fair_ids = '{3'd0, 3'd1, 3'd5, 3'd3, 3'd4, 3'd2, 3'd6, 3'd7};

    // Reset values
    do_reset;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("rst_dealloc_valid", 32'(dealloc_valid), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single requester
    do_grant(4'b0001, 3'd0, 4'b0001);
    req_valid = 4'b0000;
    rsp_id    = 3'd0;
    #1;
    chk("single_owner", 32'(rsp_owner), 32'd0);

    // Fairness: all four requesting, eight grants, ID 5 lands on requester 2
    do_reset;
    for (int k = 0; k < 8; k++) begin
      onehot = 4'b0001 << (k % 4);
      do_grant(4'b1111, fair_ids[k], onehot);
    end
    alloc_valid = 1'b1;
    alloc_id    = 3'd0;
    tick;
    chk("all_capped", 32'(req_ready), 32'd0);
    tick;
    chk("all_capped2", 32'(req_ready), 32'd0);
    req_valid   = 4'b0000;
    alloc_valid = 1'b0;
    tick;

    // Response routing for ID 5, three beats
    rsp_valid = 1'b1;
    rsp_id    = 3'd5;
    for (int b = 0; b < 3; b++) begin
      rsp_last = (b == 2);
      #1;
      chk("route_owner", 32'(rsp_owner), 32'd2);
      chk("route_ready", 32'(rsp_ready), 32'd1);
      tick;
    end
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    chk("dealloc_valid", 32'(dealloc_valid), 32'd1);
    chk("dealloc_id", 32'(dealloc_id), 32'd5);
    chk("pend_rsp_ready", 32'(rsp_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("bp_rsp_ready", 32'(rsp_ready), 32'd0);
      chk("bp_dealloc_valid", 32'(dealloc_valid), 32'd1);
    end
    dealloc_ready = 1'b1;
    tick;
    chk("done_valid", 32'(done_valid), 32'b0100);
    chk("done_id", 32'(done_id), 32'd5);
    chk("freed_dealloc_valid", 32'(dealloc_valid), 32'd0);
    chk("freed_rsp_ready", 32'(rsp_ready), 32'd1);
    dealloc_ready = 1'b0;
    tick;
    chk("done_pulse_end", 32'(done_valid), 32'd0);
    chk("no_err", 32'(err), 32'd0);

    // Cap: requester 1 alone, two grants then blocked
    do_reset;
    do_grant(4'b0010, 3'd0, 4'b0010);
    do_grant(4'b0010, 3'd1, 4'b0010);
    req_valid   = 4'b0010;
    alloc_valid = 1'b1;
    alloc_id    = 3'd2;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("cap_ready", 32'(req_ready), 32'd0);
      chk("cap_alloc_ready", 32'(alloc_ready), 32'd0);
    end

    // Error on non-busy ID 3, sticky
    rsp_valid = 1'b1;
    rsp_id    = 3'd3;
    rsp_last  = 1'b0;
    tick;
    rsp_valid = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    tick;
    chk("err_sticky", 32'(err), 32'd1);

    // Free ID 0 so requester 1 drops below its cap
    rsp_valid     = 1'b1;
    rsp_id        = 3'd0;
    rsp_last      = 1'b1;
    dealloc_ready = 1'b1;
    #1;
    chk("cap_rsp_owner", 32'(rsp_owner), 32'd1);
    tick;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    chk("cap_dealloc_valid", 32'(dealloc_valid), 32'd1);
    chk("cap_dealloc_id", 32'(dealloc_id), 32'd0);
    tick;
    chk("cap_done_valid", 32'(done_valid), 32'b0010);
    chk("cap_done_id", 32'(done_id), 32'd0);
    chk("cap_still_blocked", 32'(req_ready), 32'd0);
    tick;
    chk("cap_regrant_ready", 32'(req_ready), 32'b0010);
    chk("cap_regrant_id", 32'(req_id), 32'd2);
    alloc_valid   = 1'b0;
    req_valid     = 4'b0000;
    dealloc_ready = 1'b0;
    tick;
    chk("cap_regrant_end", 32'(req_ready), 32'd0);

    // Reset asserted during S_GRANT
    req_valid   = 4'b0001;
    alloc_valid = 1'b1;
    alloc_id    = 3'd4;
    tick;
    chk("mid_grant_ready", 32'(req_ready), 32'b0001);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_rsp_ready", 32'(rsp_ready), 32'd1);
    chk("mid_rst_dealloc_valid", 32'(dealloc_valid), 32'd0);
    chk("mid_rst_done_valid", 32'(done_valid), 32'd0);
    alloc_valid = 1'b0;
    #2;
    resetn = 1'b1;
    do_grant(4'b0001, 3'd0, 4'b0001);
    req_valid = 4'b0000;
    rsp_valid = 1'b1;
    rsp_id    = 3'd4;
    rsp_last  = 1'b0;
    tick;
    rsp_valid = 1'b0;
    chk("aborted_id_not_busy", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prism_axi_id_scheduler.md
# prism_axi_id_scheduler

Shares one `prism_axi_id_allocator` pool of AXI IDs among NREQ requesters (DMA engines) using round-robin arbitration. Tracks the owner of every outstanding ID and its per-requester outstanding count, and routes responses back to the owner. When a requester's last beat is accepted, the scheduler returns the ID to the allocator. It sits between the requester ports and the allocator, on the same clock as the AXI master.

## Interface
- NREQ, 4: number of requesters; 2..8.
- NIDS, 8: size of the ID pool; must match the allocator.
- ID_WIDTH, $clog2(NIDS): ID width.
- REQ_WIDTH, $clog2(NREQ): requester index width.
- MAX_OUT, 4: per-requester cap on outstanding IDs; 1..NIDS.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clock  in  1  the single clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester ID request; must be held until its ready.
- req_ready  out  NREQ  one-hot grant pulse; completes the request.
- req_id  out  ID_WIDTH  granted ID; valid when any req_ready bit is high.
- alloc_valid  in  1  allocator has a free ID.
- alloc_ready  out  1  consumes alloc_id.
- alloc_id  in  ID_WIDTH  free ID offered by the allocator.
- dealloc_valid  out  1  returning an ID to the allocator.
- dealloc_ready  in  1  allocator accepts the returned ID.
- dealloc_id  out  ID_WIDTH  ID being returned.
- rsp_valid  in  1  AXI response beat (R or B).
- rsp_ready  out  1  response beat accepted.
- rsp_id  in  ID_WIDTH  response ID.
- rsp_last  in  1  final beat of the transaction.
- rsp_owner  out  REQ_WIDTH  owner of rsp_id; combinational from the owner table.
- done_valid  out  NREQ  one-cycle pulse to the owner when its ID is freed.
- done_id  out  ID_WIDTH  ID reported by done_valid.
- err  out  1  sticky flag: a response arrived for an ID that is not busy.

## Operation
- State: busy[NIDS], owner[NIDS] (REQ_WIDTH each), cnt[NREQ] (width $clog2(MAX_OUT+1)), rr pointer ptr, FSM state.
- Eligibility: requester i is eligible when req_valid[i] is high and cnt[i] < MAX_OUT.
- FSM states:
  - S_ARB: if alloc_valid is high and any requester is eligible, register the winner (first eligible index at or after ptr, wrapping), then go to S_GRANT.
  - S_GRANT: drive req_ready[win]=1, alloc_ready=1 and req_id=alloc_id, all for exactly one cycle. On that edge: busy[alloc_id]<=1, owner[alloc_id]<=win, cnt[win]++, ptr<=win+1 (mod NREQ). Return to S_ARB.
- Requesters may not drop req_valid before ready; if one does, the grant still completes and the ID counts as allocated.
- Response path:
  - rsp_ready = !pend.
  - A beat accepted with rsp_last=1 sets pend<=1 and pend_id<=rsp_id.
  - A beat without rsp_last needs no state change.
  - Any accepted beat with busy[rsp_id]=0 sets err.
- Return path:
  - dealloc_valid=pend, dealloc_id=pend_id.
  - On dealloc_valid&dealloc_ready: pend<=0, busy[pend_id]<=0, cnt[owner]--, and done_valid[owner] pulses next cycle with done_id=pend_id.
- Simultaneous grant and dealloc on the same cycle: both apply. If the same requester is granted and freed, its cnt is unchanged.

## Timing
- Reset values: req_ready=0, alloc_ready=0, dealloc_valid=0, rsp_ready=1 after reset, done_valid=0, err=0, busy=0, cnt=0, ptr=0, state S_ARB.
- Grant latency: eligible request plus alloc_valid at edge t gives req_ready at cycle t+1. Maximum throughput is one grant per 2 cycles. The allocator needs ≥2 cycles to present the next ID, so it is the real limit.
- Response throughput:
  - Non-last beats: 1 per cycle.
  - Last beats: throttled by dealloc handshake; rsp_ready is low while pend is set.
- Pool exhausted (alloc_valid=0): the FSM stays in S_ARB and requests wait indefinitely.
- Requester at MAX_OUT: skipped by the arbiter; the round-robin pointer is not advanced for it.
- Reset asserted mid-grant: all state clears asynchronously. The allocator must share resetn.

## Structure
- Shared package `prism_axi_pkg`: holds the state_t enum (S_ARB, S_GRANT) and the MAX_OUT default constant.
- Sub-module `prism_rr_arbiter` (NREQ, combinational): inputs eligible mask and ptr; outputs one-hot grant and index.
- All tables and counters are in the top module.

## Test plan
- Single requester: req_valid[0]=1, allocator offers ID 0 → req_ready[0] one cycle with req_id=0; cnt[0]=1; owner[0]=0.
- Fairness: all 4 requesting continuously with a free pool → grants in order 0,1,2,3,0; 8 grants before alloc_valid falls.
- Cap: MAX_OUT=2, only requester 1 requests → 2 grants, then no further req_ready until a response with rsp_last for one of its IDs is freed.
- Response routing: ID 5 owned by requester 2, 3 beats with last on the 3rd → rsp_owner=2 on every beat; dealloc_id=5; done_valid[2] pulses with done_id=5.
- Error and backpressure:
  - rsp for non-busy ID 3 → err=1 and stays high.
  - dealloc_ready held low 4 cycles → rsp_ready low for those cycles.
- Reset mid-operation: assert resetn=0 during S_GRANT → all outputs at reset values immediately; after release, first grant returns ID 0.
